// File: rtl/markov_puf_ctrl.sv
// markov_puf_ctrl: steps LFSR challenges through the arbiter-PUF array and streams each CRP out
module markov_puf_ctrl #(
  parameter int N = 16,
  parameter int K = 8,
  parameter logic [N-1:0] POLY = 'hB400,
  parameter int SETTLE = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] seed,
  input  logic [15:0]  num_crp,
  output logic [N-1:0] puf_c,
  output logic         puf_tig,
  input  logic         puf_resp_ready,
  input  logic         puf_resp_bit,
  input  logic [K-1:0] puf_resp_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_chal,
  output logic         out_resp,
  output logic [K-1:0] out_resp_vec,
  output logic         busy,
  output logic         done,
  output logic         timeout_err
);
  localparam int CW = $clog2(TIMEOUT + SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TRIG, S_WAIT, S_CAPTURE, S_OUT, S_RELEASE, S_DONE} state_e;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [15:0] remaining_q;
  logic [N-1:0] puf_c_q, out_chal_q, lfsr_d, seed_d;
  logic [K-1:0] out_resp_vec_q;
  logic rdy_meta_q, rdy_s_q, puf_tig_q, out_valid_q, out_resp_q, busy_q, done_q, timeout_err_q;
  always_comb begin
    lfsr_d = puf_c_q[0] ? (puf_c_q >> 1) ^ POLY : puf_c_q >> 1;
    seed_d = (seed == '0) ? N'(1) : seed;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      remaining_q    <= '0;
      puf_c_q        <= '0;
      out_chal_q     <= '0;
      out_resp_vec_q <= '0;
      rdy_meta_q     <= 1'b0;
      rdy_s_q        <= 1'b0;
      puf_tig_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_resp_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      rdy_meta_q <= puf_resp_ready;
      rdy_s_q    <= rdy_meta_q;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          puf_c_q       <= seed_d;
          remaining_q   <= num_crp;
          timeout_err_q <= 1'b0;
          busy_q        <= 1'b1;
          cnt_q         <= '0;
          state_q       <= (num_crp == '0) ? S_DONE : S_LOAD;
          done_q        <= (num_crp == '0);
        end
        S_LOAD: begin
          puf_tig_q <= 1'b0;
          cnt_q     <= (cnt_q == CW'(SETTLE - 1)) ? '0 : cnt_q + 1'b1;
          state_q   <= (cnt_q == CW'(SETTLE - 1)) ? S_TRIG : S_LOAD;
        end
        S_TRIG: begin
          puf_tig_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= S_WAIT;
        end
        // ready has priority over a timeout expiring in the same cycle
        S_WAIT: if (rdy_s_q) begin
          state_q <= S_CAPTURE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_q <= 1'b1;
          puf_tig_q     <= 1'b0;
          done_q        <= 1'b1;
          state_q       <= S_DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        S_CAPTURE: begin
          out_chal_q     <= puf_c_q;
          out_resp_q     <= puf_resp_bit;
          out_resp_vec_q <= puf_resp_vec;
          puf_tig_q      <= 1'b0;
          out_valid_q    <= 1'b1;
          state_q        <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          remaining_q <= remaining_q - 1'b1;
          cnt_q       <= '0;
          state_q     <= S_RELEASE;
        end
        // arbiters must see ready fall before the next challenge is applied
        S_RELEASE: if (!rdy_s_q) begin
          puf_c_q <= (remaining_q == '0) ? puf_c_q : lfsr_d;
          done_q  <= (remaining_q == '0);
          cnt_q   <= '0;
          state_q <= (remaining_q == '0) ? S_DONE : S_LOAD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_err_q <= 1'b1;
          done_q        <= 1'b1;
          state_q       <= S_DONE;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign puf_c        = puf_c_q;
  assign puf_tig      = puf_tig_q;
  assign out_valid    = out_valid_q;
  assign out_chal     = out_chal_q;
  assign out_resp     = out_resp_q;
  assign out_resp_vec = out_resp_vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
endmodule
